missionary_cannibal_checker: RTL and testbench
==============================================

MISSIONARY_CANNIBAL_CHECKER -- requirements
Module: missionary_cannibal_checker

Interface
REQ-001 Parameter MAX_STEPS, default 15; number of accepted moves after which a run is declared overflowed.
REQ-002 clock  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  producer presents a bank configuration this cycle.
REQ-005 missionary_in  input  2  missionaries on the original (left) bank after the move.
REQ-006 cannibal_in  input  2  cannibals on the original (left) bank after the move.
REQ-007 in_ready  output  1  checker accepts a sample this cycle.
REQ-008 finish  output  3  3'b001 while in DONE, else 3'b000.
REQ-009 error  output  1  high while in FAIL.
REQ-010 error_code  output  3  cause of failure, held while in FAIL, 3'b000 otherwise.
REQ-011 step_count  output  4  moves accepted in the current run, saturating at MAX_STEPS.
REQ-012 boat_side  output  1  0 = boat on left bank, 1 = boat on right bank.

Function
REQ-013 A sample is accepted on a rising edge when in_valid and in_ready are both high; no other cycle changes checker state.
REQ-014 in_ready is combinational from state: high in WAIT_INIT, RUN and DONE; low in FAIL.
REQ-015 All other outputs are registered and reflect an accepted sample one cycle after acceptance.
REQ-016 States: WAIT_INIT, RUN, DONE, FAIL.
REQ-017 WAIT_INIT: an accepted (3,3) moves to RUN with boat_side=0 and step_count=0; any other value moves to FAIL with code 3'b001 (BAD_INIT).
REQ-018 RUN: compute dm = prev_m - missionary_in and dc = prev_c - cannibal_in as signed 3-bit values, where prev is the last accepted configuration.
REQ-019 With boat_side=0, dm and dc shall both be >= 0; with boat_side=1, both shall be <= 0; otherwise FAIL with code 3'b010 (BAD_DIR).
REQ-020 The boat load |dm|+|dc| shall be 1 or 2; a load of 0 or greater than 2 moves to FAIL with code 3'b011 (BAD_LOAD).
REQ-021 Both banks shall be safe: left bank safe when m==0 or m>=c; right bank safe when (3-m)==0 or (3-m)>=(3-c); otherwise FAIL with code 3'b100 (UNSAFE).
REQ-022 An input value of 3 is legal for either count; no count can exceed 3 because the inputs are 2 bits wide.
REQ-023 Error priority, highest first: BAD_DIR, BAD_LOAD, UNSAFE, STEP_OVF. Only the highest-priority error is reported.
REQ-024 On a legal move: toggle boat_side, increment step_count and store the configuration as prev.
REQ-025 A legal move reaching (0,0) with the new boat_side=1 moves to DONE.
REQ-026 A legal move that does not reach DONE and brings step_count to MAX_STEPS moves to FAIL with code 3'b101 (STEP_OVF).
REQ-027 DONE: an accepted (3,3) starts a new run: go to RUN with step_count=0, boat_side=0 and finish cleared. Any other accepted value moves to FAIL with code 3'b001.
REQ-028 FAIL is sticky until reset, and every output holds its value in FAIL.

Reset
REQ-029 On reset the checker enters WAIT_INIT with finish=3'b000, error=0, error_code=3'b000, step_count=0, boat_side=0, and prev=(3,3).
REQ-030 Reset asserted mid-run or in DONE/FAIL takes priority over a simultaneous accepted sample, and that sample is discarded.

Structure
REQ-031 Shared package mc_pkg holds: the state enum; the error-code constants (NONE, BAD_INIT, BAD_DIR, BAD_LOAD, UNSAFE, STEP_OVF); TOTAL=3; the FINISH_DONE=3'b001 constant.
REQ-032 The pure-combinational legality check (direction, load, bank safety, error priority) shall be the single sub-module mc_move_legal; the top holds the FSM and the registers.

Verification
REQ-033 Reset, then feed the optimal 12-sample solution (3,3),(3,1),(3,2),(3,0),(3,1),(1,1),(2,2),(0,2),(0,3),(0,1),(0,2),(0,0) -> finish=001, step_count=11, boat_side=1, error=0.
REQ-034 Reset, then feed (3,2) as the first sample -> error=1, error_code=001, in_ready=0 on the next cycle.
REQ-035 Feed (3,3),(2,3) -> error_code=100 (UNSAFE); feed (3,3),(3,3) -> error_code=011 (BAD_LOAD).
REQ-036 Feed (3,3),(3,1),(3,0) -> error_code=010 (BAD_DIR), because the return trip removes people from the left bank.
REQ-037 Complete a solution, then feed (3,3) -> finish=000, step_count=0, state RUN; assert reset together with an in_valid sample mid-run -> outputs at reset values and the sample ignored.
REQ-038 Hold in_valid low for 20 cycles mid-run -> no output changes; toggle (3,3)<->(3,1) pairs with MAX_STEPS=15 -> error_code=101 after the 15th move.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the missionaries-and-cannibals move checker.
//   mc_state_e  : checker FSM states
//   ERR_*       : failure cause codes reported on error_code
//   TOTAL       : people of each kind in the puzzle
//   FINISH_DONE : finish value while a run is complete
package mc_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_INIT = 2'd0,
        ST_RUN       = 2'd1,
        ST_DONE      = 2'd2,
        ST_FAIL      = 2'd3
    } mc_state_e;

    localparam logic [2:0] ERR_NONE     = 3'b000;
    localparam logic [2:0] ERR_BAD_INIT = 3'b001;
    localparam logic [2:0] ERR_BAD_DIR  = 3'b010;
    localparam logic [2:0] ERR_BAD_LOAD = 3'b011;
    localparam logic [2:0] ERR_UNSAFE   = 3'b100;
    localparam logic [2:0] ERR_STEP_OVF = 3'b101;

    localparam logic [1:0] TOTAL       = 2'd3;
    localparam logic [2:0] FINISH_DONE = 3'b001;

endpackage

// File: rtl/mc_move_legal.sv
// Pure combinational legality check of one move.
//   prev_m/prev_c : left-bank counts before the move
//   cur_m/cur_c   : left-bank counts after the move
//   boat_side     : 0 = boat on left (people leave left), 1 = boat on right
//   legal         : move is legal
//   err_code      : highest-priority failure (BAD_DIR > BAD_LOAD > UNSAFE), NONE if legal
module mc_move_legal
    import mc_pkg::*;
(
    input  logic [1:0] prev_m,
    input  logic [1:0] prev_c,
    input  logic [1:0] cur_m,
    input  logic [1:0] cur_c,
    input  logic       boat_side,
    output logic       legal,
    output logic [2:0] err_code
);

    logic signed [2:0] dm, dc;
    logic [2:0] neg_dm, neg_dc;
    logic [1:0] abs_dm, abs_dc;
    logic [2:0] load;
    logic [1:0] right_m, right_c;
    logic       dir_ok, load_ok, left_safe, right_safe;

    always_comb begin
        dm      = $signed({1'b0, prev_m} - {1'b0, cur_m});
        dc      = $signed({1'b0, prev_c} - {1'b0, cur_c});
        neg_dm  = 3'd0 - dm;
        neg_dc  = 3'd0 - dc;
        abs_dm  = dm[2] ? neg_dm[1:0] : dm[1:0];
        abs_dc  = dc[2] ? neg_dc[1:0] : dc[1:0];
        load    = {1'b0, abs_dm} + {1'b0, abs_dc};

        // boat on the left carries people away from the left bank, and back again otherwise
        dir_ok  = boat_side ? (dm <= 3'sd0 && dc <= 3'sd0)
                            : (dm >= 3'sd0 && dc >= 3'sd0);
        load_ok = (load == 3'd1) || (load == 3'd2);

        right_m    = TOTAL - cur_m;
        right_c    = TOTAL - cur_c;
        left_safe  = (cur_m == 2'd0) || (cur_m >= cur_c);
        right_safe = (right_m == 2'd0) || (right_m >= right_c);

        err_code = ERR_NONE;
        if (!dir_ok)                        err_code = ERR_BAD_DIR;
        else if (!load_ok)                  err_code = ERR_BAD_LOAD;
        else if (!(left_safe && right_safe)) err_code = ERR_UNSAFE;
        legal = (err_code == ERR_NONE);
    end

endmodule

// File: rtl/missionary_cannibal_checker.sv
// Streaming checker for missionaries-and-cannibals solutions.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   in_valid          : a left-bank configuration is presented
//   missionary_in     : missionaries on the left bank after the move
//   cannibal_in       : cannibals on the left bank after the move
//   in_ready          : sample accepted this cycle (low only in FAIL)
//   finish            : FINISH_DONE while a run is complete
//   error, error_code : failure flag and sticky cause
//   step_count        : moves accepted in the run, saturating at MAX_STEPS
//   boat_side         : 0 = left bank, 1 = right bank
module missionary_cannibal_checker
    import mc_pkg::*;
#(
    parameter int MAX_STEPS = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] missionary_in,
    input  logic [1:0] cannibal_in,
    output logic       in_ready,
    output logic [2:0] finish,
    output logic       error,
    output logic [2:0] error_code,
    output logic [3:0] step_count,
    output logic       boat_side
);

    localparam logic [3:0] MAX_W = 4'(MAX_STEPS);

    mc_state_e  state_q, state_d;
    logic [1:0] prev_m_q, prev_m_d, prev_c_q, prev_c_d;
    logic [3:0] step_count_q, step_count_d;
    logic       boat_side_q, boat_side_d;
    logic [2:0] error_code_q, error_code_d;

    logic       mv_legal;
    logic [2:0] mv_err;
    logic       accept, is_init, is_goal;
    logic [3:0] step_inc;

    mc_move_legal u_legal (
        .prev_m    (prev_m_q),
        .prev_c    (prev_c_q),
        .cur_m     (missionary_in),
        .cur_c     (cannibal_in),
        .boat_side (boat_side_q),
        .legal     (mv_legal),
        .err_code  (mv_err)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_WAIT_INIT;
            prev_m_q     <= TOTAL;
            prev_c_q     <= TOTAL;
            step_count_q <= 4'd0;
            boat_side_q  <= 1'b0;
            error_code_q <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            prev_m_q     <= prev_m_d;
            prev_c_q     <= prev_c_d;
            step_count_q <= step_count_d;
            boat_side_q  <= boat_side_d;
            error_code_q <= error_code_d;
        end
    end

    // Next-state logic; nothing moves unless a sample is accepted
    always_comb begin
        state_d      = state_q;
        prev_m_d     = prev_m_q;
        prev_c_d     = prev_c_q;
        step_count_d = step_count_q;
        boat_side_d  = boat_side_q;
        error_code_d = error_code_q;

        accept   = in_valid && in_ready;
        is_init  = (missionary_in == TOTAL) && (cannibal_in == TOTAL);
        is_goal  = (missionary_in == 2'd0) && (cannibal_in == 2'd0);
        step_inc = (step_count_q == MAX_W) ? MAX_W : step_count_q + 4'd1;

        case (state_q)
            ST_WAIT_INIT, ST_DONE: begin
                if (accept) begin
                    if (is_init) begin
                        state_d      = ST_RUN;
                        prev_m_d     = TOTAL;
                        prev_c_d     = TOTAL;
                        step_count_d = 4'd0;
                        boat_side_d  = 1'b0;
                    end else begin
                        state_d      = ST_FAIL;
                        error_code_d = ERR_BAD_INIT;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (!mv_legal) begin
                        state_d      = ST_FAIL;
                        error_code_d = mv_err;
                    end else begin
                        prev_m_d     = missionary_in;
                        prev_c_d     = cannibal_in;
                        step_count_d = step_inc;
                        boat_side_d  = ~boat_side_q;
                        // goal only counts once the boat has landed on the right bank
                        if (is_goal && !boat_side_q) begin
                            state_d = ST_DONE;
                        end else if (step_inc == MAX_W) begin
                            state_d      = ST_FAIL;
                            error_code_d = ERR_STEP_OVF;
                        end
                    end
                end
            end
            default: ;  // FAIL is sticky until reset
        endcase
    end

    // Outputs
    always_comb begin
        in_ready   = (state_q != ST_FAIL);
        finish     = (state_q == ST_DONE) ? FINISH_DONE : 3'b000;
        error      = (state_q == ST_FAIL);
        error_code = error_code_q;
        step_count = step_count_q;
        boat_side  = boat_side_q;
    end

endmodule

// File: tb/tb_missionary_cannibal_checker.sv
module tb_missionary_cannibal_checker;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] missionary_in = 2'd0;
    logic [1:0] cannibal_in = 2'd0;
    logic       in_ready;
    logic [2:0] finish;
    logic       error;
    logic [2:0] error_code;
    logic [3:0] step_count;
    logic       boat_side;

    int checks = 0;
    int errors = 0;

    logic [1:0] sol_m [12] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0] sol_c [12] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};

    missionary_cannibal_checker #(.MAX_STEPS(15)) dut (
        .clock         (clock),
        .reset         (reset),
        .in_valid      (in_valid),
        .missionary_in (missionary_in),
        .cannibal_in   (cannibal_in),
        .in_ready      (in_ready),
        .finish        (finish),
        .error         (error),
        .error_code    (error_code),
        .step_count    (step_count),
        .boat_side     (boat_side)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one accepted-or-offered sample; returns #1 after the capturing edge
    task automatic send(input logic [1:0] m, input logic [1:0] c);
        @(negedge clock);
        in_valid      = 1'b1;
        missionary_in = m;
        cannibal_in   = c;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_solution(input logic check_steps);
        for (int i = 0; i < 12; i++) begin
            send(sol_m[i], sol_c[i]);
            if (check_steps) begin
                chk($sformatf("sol_step%0d", i), 32'(step_count), 32'(i));
                chk($sformatf("sol_boat%0d", i), 32'(boat_side), 32'(i % 2));
            end
        end
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_code", 32'(error_code), 32'd0);
        chk("rst_step", 32'(step_count), 32'd0);
        chk("rst_boat", 32'(boat_side), 32'd0);

        // full optimal solution
        run_solution(1'b1);
        chk("sol_finish", 32'(finish), 32'd1);
        chk("sol_step", 32'(step_count), 32'd11);
        chk("sol_boat", 32'(boat_side), 32'd1);
        chk("sol_error", 32'(error), 32'd0);
        chk("sol_ready", 32'(in_ready), 32'd1);

        // restart from DONE
        send(2'd3, 2'd3);
        chk("rs_finish", 32'(finish), 32'd0);
        chk("rs_step", 32'(step_count), 32'd0);
        chk("rs_boat", 32'(boat_side), 32'd0);
        chk("rs_error", 32'(error), 32'd0);
        send(2'd3, 2'd1);
        chk("rs_run_step", 32'(step_count), 32'd1);
        chk("rs_run_boat", 32'(boat_side), 32'd1);
        chk("rs_run_err", 32'(error), 32'd0);

        // idle cycles with garbage on the data inputs
        missionary_in = 2'd0;
        cannibal_in   = 2'd2;
        repeat (20) @(posedge clock);
        #1;
        chk("idle_step", 32'(step_count), 32'd1);
        chk("idle_boat", 32'(boat_side), 32'd1);
        chk("idle_err", 32'(error), 32'd0);
        chk("idle_finish", 32'(finish), 32'd0);

        // reset wins over a simultaneous legal sample (3,2)
        @(negedge clock);
        reset         = 1'b1;
        in_valid      = 1'b1;
        missionary_in = 2'd3;
        cannibal_in   = 2'd2;
        @(posedge clock);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rsv_step", 32'(step_count), 32'd0);
        chk("rsv_boat", 32'(boat_side), 32'd0);
        chk("rsv_error", 32'(error), 32'd0);
        chk("rsv_code", 32'(error_code), 32'd0);
        chk("rsv_ready", 32'(in_ready), 32'd1);
        send(2'd3, 2'd3);
        chk("rsv_init_err", 32'(error), 32'd0);
        send(2'd3, 2'd1);
        chk("rsv_move_step", 32'(step_count), 32'd1);
        chk("rsv_move_err", 32'(error), 32'd0);

        // bad first sample, then FAIL holds
        do_reset();
        send(2'd3, 2'd2);
        chk("binit_error", 32'(error), 32'd1);
        chk("binit_code", 32'(error_code), 32'd1);
        chk("binit_ready", 32'(in_ready), 32'd0);
        send(2'd3, 2'd3);
        chk("fail_hold_code", 32'(error_code), 32'd1);
        chk("fail_hold_err", 32'(error), 32'd1);
        chk("fail_hold_step", 32'(step_count), 32'd0);

        // UNSAFE
        do_reset();
        send(2'd3, 2'd3);
        send(2'd2, 2'd3);
        chk("unsafe_code", 32'(error_code), 32'd4);
        chk("unsafe_err", 32'(error), 32'd1);

        // BAD_LOAD (empty boat)
        do_reset();
        send(2'd3, 2'd3);
        send(2'd3, 2'd3);
        chk("load0_code", 32'(error_code), 32'd3);

        // BAD_LOAD (three people, direction fine)
        do_reset();
        send(2'd3, 2'd3);
        send(2'd2, 2'd1);
        chk("load3_code", 32'(error_code), 32'd3);

        // BAD_DIR on the return trip
        do_reset();
        send(2'd3, 2'd3);
        send(2'd3, 2'd1);
        send(2'd3, 2'd0);
        chk("dir_code", 32'(error_code), 32'd2);
        chk("dir_step", 32'(step_count), 32'd1);
        chk("dir_boat", 32'(boat_side), 32'd1);

        // non-(3,3) sample after DONE
        do_reset();
        run_solution(1'b0);
        send(2'd3, 2'd2);
        chk("done_bad_code", 32'(error_code), 32'd1);
        chk("done_bad_finish", 32'(finish), 32'd0);
        chk("done_bad_err", 32'(error), 32'd1);

        // step overflow by shuttling (3,3) <-> (3,1)
        do_reset();
        send(2'd3, 2'd3);
        for (int i = 1; i <= 14; i++) begin
            if (i % 2 == 1) send(2'd3, 2'd1);
            else            send(2'd3, 2'd3);
        end
        chk("ovf14_err", 32'(error), 32'd0);
        chk("ovf14_step", 32'(step_count), 32'd14);
        send(2'd3, 2'd1);
        chk("ovf_code", 32'(error_code), 32'd5);
        chk("ovf_err", 32'(error), 32'd1);
        chk("ovf_step", 32'(step_count), 32'd15);
        chk("ovf_ready", 32'(in_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
